// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with I/D memory, raises sticky traps.
// `define CTRL_MULDIV_EN adds the MULDIV state and the md_start/md_done handshake for M-extension OP encodings.
module multicycle_control #(
   parameter int TIMEOUT_W      = 4,
   parameter int RESET_PC_WRITE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        branch_taken,
`ifdef CTRL_MULDIV_EN
   input  logic        md_done,
   output logic        md_start,
`endif
   output logic        imem_req,
   output logic        dmem_req,
   output logic        ir_load,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic [2:0]  immediate_control,
   output logic [1:0]  alu_operation,
   output logic        alu_src1,
   output logic        alu_src2,
   output logic        mem_to_reg,
   output logic        jump,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        illegal,
   output logic        mem_fault,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
      S_WB = 3'd4, S_TRAP = 3'd5, S_MULDIV = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_MULDIV, C_ILL
   } cls_t;

   // Waiting cycle n (counting from 1) sees a count of n-1, so cycle 2**TIMEOUT_W-1 is the last chance for an ack.
   localparam logic [TIMEOUT_W-1:0] TERM = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

   state_t               st, st_n;
   cls_t                 dec_cls, cls_q, cls;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_n;
   logic                 ill_q, flt_q, first_q, set_ill, set_flt;
   logic [2:0]           cls_imm;
   logic [1:0]           cls_aop;
   logic                 cls_s1, cls_s2;
   logic                 unused_instr;

   assign unused_instr = ^instr[24:7];

   always_comb begin
      dec_cls = C_ILL;
      case (instr[6:0])
         7'b0110011: begin
            if (instr[31:25] == 7'b0000001) begin
`ifdef CTRL_MULDIV_EN
               dec_cls = C_MULDIV;
`else
               dec_cls = C_ILL;
`endif
            end else begin
               dec_cls = C_OP;
            end
         end
         7'b0010011: dec_cls = C_OPIMM;
         7'b0110111: dec_cls = C_LUI;
         7'b0010111: dec_cls = C_AUIPC;
         7'b1101111: dec_cls = C_JAL;
         7'b1100111: dec_cls = C_JALR;
         7'b1100011: dec_cls = C_BRANCH;
         7'b0000011: dec_cls = C_LOAD;
         7'b0100011: dec_cls = C_STORE;
         default:    dec_cls = C_ILL;
      endcase
   end

   // The class is captured on leaving DECODE; later states never look at the opcode again.
   assign cls = (st == S_DECODE) ? dec_cls : cls_q;

   always_comb begin
      cls_imm = 3'b000;
      cls_aop = 2'b00;
      cls_s1  = 1'b0;
      cls_s2  = 1'b0;
      case (cls)
         C_OP, C_MULDIV: cls_aop = 2'b11;
         C_OPIMM:  begin cls_imm = 3'b001; cls_aop = 2'b11; cls_s2 = 1'b1; end
         C_LUI:    cls_imm = 3'b100;
         C_AUIPC:  begin cls_imm = 3'b100; cls_aop = 2'b10; cls_s1 = 1'b1; cls_s2 = 1'b1; end
         C_JAL:    begin cls_imm = 3'b101; cls_aop = 2'b10; cls_s1 = 1'b1; cls_s2 = 1'b1; end
         C_JALR:   begin cls_imm = 3'b001; cls_aop = 2'b10; cls_s2 = 1'b1; end
         C_BRANCH: begin cls_imm = 3'b011; cls_aop = 2'b01; end
         C_LOAD:   begin cls_imm = 3'b001; cls_aop = 2'b10; cls_s2 = 1'b1; end
         C_STORE:  begin cls_imm = 3'b010; cls_aop = 2'b10; cls_s2 = 1'b1; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st      <= S_FETCH;
         cls_q   <= C_ILL;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         flt_q   <= 1'b0;
         first_q <= 1'b1;
      end else begin
         st      <= st_n;
         if (st == S_DECODE) cls_q <= dec_cls;
         cnt_q   <= cnt_n;
         ill_q   <= ill_q | set_ill;
         flt_q   <= flt_q | set_flt;
         first_q <= 1'b0;
      end
   end

   // Counting only while parked in a request state means any entry into FETCH or MEM starts from zero.
   assign cnt_n = ((st == S_FETCH || st == S_MEM) && st_n == st) ? cnt_q + 1'b1 : '0;

   always_comb begin
      st_n              = st;
      set_ill           = 1'b0;
      set_flt           = 1'b0;
      imem_req          = 1'b0;
      dmem_req          = 1'b0;
      ir_load           = 1'b0;
      pc_write          = 1'b0;
      pc_sel            = 2'b00;
      immediate_control = 3'b000;
      alu_operation     = 2'b00;
      alu_src1          = 1'b0;
      alu_src2          = 1'b0;
      mem_to_reg        = 1'b0;
      jump              = 1'b0;
      reg_write         = 1'b0;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
`ifdef CTRL_MULDIV_EN
      md_start          = 1'b0;
`endif
      case (st)
         S_FETCH: begin
            imem_req = 1'b1;
            pc_write = (RESET_PC_WRITE != 0) && first_q;
            if (imem_ack) begin
               ir_load = 1'b1;
               st_n    = S_DECODE;
            end else if (cnt_q == TERM) begin
               set_flt = 1'b1;
               st_n    = S_TRAP;
            end
         end
         S_DECODE: begin
            immediate_control = cls_imm;
            if (cls == C_ILL) begin
               set_ill = 1'b1;
               st_n    = S_TRAP;
            end else if (cls == C_LUI) begin
               st_n = S_WB;
            end else begin
               st_n = S_EXEC;
            end
         end
         S_EXEC: begin
            immediate_control = cls_imm;
            alu_operation     = cls_aop;
            alu_src1          = cls_s1;
            alu_src2          = cls_s2;
            case (cls)
               C_BRANCH: begin
                  pc_write = 1'b1;
                  pc_sel   = {1'b0, branch_taken};
                  st_n     = S_FETCH;
               end
               C_LOAD, C_STORE: st_n = S_MEM;
`ifdef CTRL_MULDIV_EN
               C_MULDIV: begin
                  md_start = 1'b1;
                  st_n     = S_MULDIV;
               end
`endif
               default: st_n = S_WB;
            endcase
         end
         S_MEM: begin
            immediate_control = cls_imm;
            alu_operation     = cls_aop;
            alu_src1          = cls_s1;
            alu_src2          = cls_s2;
            dmem_req          = 1'b1;
            mem_read          = (cls == C_LOAD);
            mem_write         = (cls == C_STORE);
            if (dmem_ack) begin
               if (cls == C_LOAD) begin
                  st_n = S_WB;
               end else begin
                  pc_write = 1'b1;
                  st_n     = S_FETCH;
               end
            end else if (cnt_q == TERM) begin
               set_flt = 1'b1;
               st_n    = S_TRAP;
            end
         end
         S_WB: begin
            // ALU stays configured so the JALR target is still on its output when the PC loads.
            immediate_control = cls_imm;
            alu_operation     = cls_aop;
            alu_src1          = cls_s1;
            alu_src2          = cls_s2;
            reg_write         = 1'b1;
            pc_write          = 1'b1;
            mem_to_reg        = (cls == C_LOAD);
            jump              = (cls == C_JAL) || (cls == C_JALR);
            pc_sel            = (cls == C_JAL) ? 2'b01 : (cls == C_JALR) ? 2'b10 : 2'b00;
            st_n              = S_FETCH;
         end
`ifdef CTRL_MULDIV_EN
         S_MULDIV: begin
            if (md_done) st_n = S_WB;
         end
`endif
         default: ;
      endcase
      if (rst) begin
         imem_req          = 1'b0;
         dmem_req          = 1'b0;
         ir_load           = 1'b0;
         pc_write          = 1'b0;
         pc_sel            = 2'b00;
         immediate_control = 3'b000;
         alu_operation     = 2'b00;
         alu_src1          = 1'b0;
         alu_src2          = 1'b0;
         mem_to_reg        = 1'b0;
         jump              = 1'b0;
         reg_write         = 1'b0;
         mem_read          = 1'b0;
         mem_write         = 1'b0;
`ifdef CTRL_MULDIV_EN
         md_start          = 1'b0;
`endif
      end
   end

   assign illegal   = ill_q;
   assign mem_fault = flt_q;
   assign state     = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction cycle scripts built from the instruction rules feed a scoreboard.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
   logic        imem_req, dmem_req, ir_load, pc_write;
   logic [1:0]  pc_sel;
   logic [2:0]  immediate_control;
   logic [1:0]  alu_operation;
   logic        alu_src1, alu_src2, mem_to_reg, jump, reg_write, mem_read, mem_write;
   logic        illegal, mem_fault;
   logic [2:0]  state;

   multicycle_control #(.TIMEOUT_W(4), .RESET_PC_WRITE(0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load),
      .pc_write(pc_write), .pc_sel(pc_sel), .immediate_control(immediate_control),
      .alu_operation(alu_operation), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .mem_to_reg(mem_to_reg), .jump(jump), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .illegal(illegal), .mem_fault(mem_fault), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       ireq, dreq, irl, pcw;
      logic [1:0] psel;
      logic [2:0] imm;
      logic [1:0] aop;
      logic       s1, s2, m2r, jmp, rw, mr, mw, ill, flt;
   } ov_t;

   typedef struct packed {
      ov_t         exp;
      ov_t         care;
      logic [47:0] tag;
   } item_t;

   localparam int K_OP = 0, K_OPIMM = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5,
                  K_BR = 6, K_LD = 7, K_ST = 8, K_ILL = 9;
   // Per-class decoder table: immediate kind, ALU operation, PC/immediate operand selects.
   int imm_tab [10] = '{0, 1, 4, 4, 5, 1, 3, 1, 2, 0};
   int aop_tab [10] = '{3, 3, 0, 2, 2, 2, 1, 2, 2, 0};
   int s1_tab  [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
   int s2_tab  [10] = '{0, 1, 0, 1, 1, 1, 0, 1, 1, 0};
   logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};

   item_t sb[$];
   item_t it;
   ov_t   got, care0, careall;
   int    checks = 0, errors = 0, cyc = 0;

   assign got = {state, imem_req, dmem_req, ir_load, pc_write, pc_sel, immediate_control,
                 alu_operation, alu_src1, alu_src2, mem_to_reg, jump, reg_write, mem_read,
                 mem_write, illegal, mem_fault};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int kind(input logic [31:0] i);
      case (i[6:0])
         7'h33:   return (i[31:25] == 7'b0000001) ? K_ILL : K_OP;
         7'h13:   return K_OPIMM;
         7'h37:   return K_LUI;
         7'h17:   return K_AUIPC;
         7'h6f:   return K_JAL;
         7'h67:   return K_JALR;
         7'h63:   return K_BR;
         7'h03:   return K_LD;
         7'h23:   return K_ST;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic drive(input logic r, input logic ia, input logic da, input logic bt,
                        input logic [31:0] ins, input ov_t e, input ov_t c, input logic [47:0] tag);
      item_t x;
      @(posedge clk);
      #1;
      rst = r; imem_ack = ia; dmem_ack = da; branch_taken = bt; instr = ins;
      x.exp = e; x.care = c; x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic do_reset(input int n, input logic [31:0] ins);
      for (int i = 0; i < n; i++) drive(1'b1, rbit(), rbit(), rbit(), ins, '0, careall, "RESET");
   endtask

   task automatic trap(input logic ill, input logic flt, input logic [31:0] ins);
      ov_t e;
      e = '0; e.st = 3'd5; e.ill = ill; e.flt = flt;
      for (int i = 0; i < 3; i++) drive(1'b0, rbit(), rbit(), rbit(), ins, e, careall, "TRAP");
      do_reset(2, ins);
   endtask

   // di/dd: ack delay in cycles (>= 15 never acks); abort_at: MEM cycle in which rst is raised (-1 none).
   task automatic run_instr(input logic [31:0] ins, input int di, input int dd, input logic bt, input int abort_at);
      int  k;
      ov_t e, c;
      k = kind(ins);
      for (int i = 0; i <= di && i < 15; i++) begin
         e = '0; c = care0; e.ireq = 1'b1; e.irl = (i == di);
         drive(1'b0, (i == di), rbit(), rbit(), (i == di) ? ins : $urandom(), e, c, "FETCH");
      end
      if (di >= 15) begin trap(1'b0, 1'b1, ins); return; end
      e = '0; c = care0; e.st = 3'd1;
      if (k != K_ILL) begin e.imm = 3'(imm_tab[k]); c.imm = 3'b111; end
      drive(1'b0, rbit(), rbit(), rbit(), ins, e, c, "DECODE");
      if (k == K_ILL) begin trap(1'b1, 1'b0, ins); return; end
      if (k != K_LUI) begin
         e = '0; c = care0; e.st = 3'd2;
         e.aop = 2'(aop_tab[k]); e.s1 = 1'(s1_tab[k]); e.s2 = 1'(s2_tab[k]);
         c.aop = 2'b11; c.s1 = 1'b1; c.s2 = 1'b1;
         if (k == K_BR) begin e.pcw = 1'b1; e.psel = {1'b0, bt}; c.psel = 2'b11; end
         drive(1'b0, rbit(), rbit(), bt, ins, e, c, "EXEC");
         if (k == K_BR) return;
         if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= dd && i < 15; i++) begin
               if (i == abort_at) begin
                  drive(1'b1, rbit(), rbit(), rbit(), ins, '0, careall, "RESET");
                  do_reset(1, ins);
                  return;
               end
               e = '0; c = care0; e.st = 3'd3; e.dreq = 1'b1;
               e.mr = (k == K_LD); e.mw = (k == K_ST);
               if (k == K_ST && i == dd) begin e.pcw = 1'b1; c.psel = 2'b11; end
               drive(1'b0, rbit(), (i == dd), rbit(), ins, e, c, "MEM");
            end
            if (dd >= 15) begin trap(1'b0, 1'b1, ins); return; end
            if (k == K_ST) return;
         end
      end
      e = '0; c = care0; e.st = 3'd4; e.rw = 1'b1; e.pcw = 1'b1;
      e.m2r = (k == K_LD); e.jmp = (k == K_JAL || k == K_JALR);
      e.psel = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00; c.psel = 2'b11;
      drive(1'b0, rbit(), rbit(), rbit(), ins, e, c, "WB");
   endtask

   // Monitor: every cycle the stimulus scripted is compared on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            it = sb.pop_front();
            checks++;
            if (((got ^ it.exp) & it.care) != '0) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%h want=%h care=%h", it.tag, cyc, got, it.exp, it.care);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=%h want=finish", cyc, got);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      int          di, dd, ab;
      careall = '1;
      care0 = '1; care0.imm = '0; care0.aop = '0; care0.s1 = 1'b0; care0.s2 = 1'b0; care0.psel = '0;

      do_reset(2, 32'h0);
      run_instr(32'h00500093, 0, 0, 1'b0, -1);   // addi x1,x0,5
      run_instr(32'h0000a103, 0, 3, 1'b0, -1);   // lw, data ack after 3 waits
      run_instr(32'h00208463, 0, 0, 1'b1, -1);   // beq taken
      run_instr(32'h00208463, 1, 0, 1'b0, -1);   // beq not taken
      run_instr(32'hffffffff, 0, 0, 1'b0, -1);   // opcode 1111111
      run_instr(32'h00500093, 15, 0, 1'b0, -1);  // fetch timeout
      run_instr(32'h00500093, 14, 0, 1'b0, -1);  // ack on the terminal cycle
      run_instr(32'h0020a023, 0, 3, 1'b0, 1);    // sw, reset during MEM
      run_instr(32'h0020a023, 0, 15, 1'b0, -1);  // store timeout
      run_instr(32'h0020a023, 2, 14, 1'b0, -1);  // store ack on the terminal cycle
      run_instr(32'h02208033, 0, 0, 1'b0, -1);   // mul encoding, trapped in this build
      run_instr(32'h0000006f, 0, 0, 1'b0, -1);   // jal
      run_instr(32'h00008067, 0, 0, 1'b0, -1);   // jalr
      run_instr(32'h000010b7, 0, 0, 1'b0, -1);   // lui
      run_instr(32'h00001097, 0, 0, 1'b0, -1);   // auipc

      for (int n = 0; n < 150; n++) begin
         ins = $urandom();
         if ($urandom_range(0, 19) != 0) ins[6:0] = ops[$urandom_range(0, 8)];
         di = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
         dd = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
         ab = -1;
         if ($urandom_range(0, 15) == 0) ab = int'($urandom_range(0, dd));
         run_instr(ins, di, dd, rbit(), ab);
      end

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
